tdm_demux_1to8: RTL and testbench

//  - Time-division 1:8 demultiplexer: receives a serial stream (one channel bit per valid beat,

---
 rtl/tdm_demux_pkg.sv | 19 +
 rtl/tdm_demux_1to8_if.sv | 26 ++
 rtl/tdm_demux_1to8.sv | 127 ++++++++++++
 tb/tb_tdm_demux_1to8.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/tdm_demux_pkg.sv
// Shared constants, state encoding and parity helper for the 1:N TDM demultiplexer.
//   NUM_CH : channels per frame (power of 2, >= 2)
//   SEL_W  : channel index width, $clog2(NUM_CH)
package tdm_demux_pkg;

    localparam int unsigned NUM_CH = 8;
    localparam int unsigned SEL_W  = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Even parity bit over one frame of channel data.
    function automatic logic even_parity(input logic [NUM_CH-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/tdm_demux_1to8_if.sv
// Serial-in / parallel-out bus of the TDM demultiplexer.
//   master : serial source, drives din/din_valid/frame_sync, observes frame outputs
//   slave  : demultiplexer, the reverse
interface tdm_demux_1to8_if;

    logic                              din;
    logic                              din_valid;
    logic                              frame_sync;
    logic [tdm_demux_pkg::NUM_CH-1:0]  y;
    logic                              frame_valid;
    logic [tdm_demux_pkg::SEL_W-1:0]   ch_idx;
    logic                              locked;
    logic                              sync_err;
    logic                              parity_err;

    modport master (
        output din, din_valid, frame_sync,
        input  y, frame_valid, ch_idx, locked, sync_err, parity_err
    );

    modport slave (
        input  din, din_valid, frame_sync,
        output y, frame_valid, ch_idx, locked, sync_err, parity_err
    );

endinterface

// File: rtl/tdm_demux_1to8.sv
// Time-division 1:8 demultiplexer. Collects one channel bit per valid beat, channel 0
// flagged by frame_sync, and publishes the completed parallel word on y with a one-cycle
// frame_valid pulse. y holds the last good frame; partial frames never reach it.
// Ports:
//   clk, rst_n       : clock, synchronous active-low reset
//   bus (slave)      : din, din_valid, frame_sync in; y, frame_valid, ch_idx, locked,
//                      sync_err, parity_err out (all registered)
// Optional macro TDM_DEMUX_PARITY_EN: each frame carries a trailing even-parity beat;
// a mismatch pulses parity_err and leaves y unchanged.
module tdm_demux_1to8
    import tdm_demux_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    tdm_demux_1to8_if.slave bus
);

`ifdef TDM_DEMUX_PARITY_EN
    // Counter reaches NUM_CH on the parity beat.
    localparam int unsigned CNT_W = SEL_W + 1;
    localparam int unsigned FINAL = NUM_CH;
`else
    localparam int unsigned CNT_W = SEL_W;
    localparam int unsigned FINAL = NUM_CH - 1;
`endif

    state_e              state_q,       state_d;
    logic [CNT_W-1:0]    cnt_q,         cnt_d;
    logic [SEL_W-1:0]    ch_idx_q,      ch_idx_d;
    logic [NUM_CH-1:0]   shadow_q,      shadow_d;
    logic [NUM_CH-1:0]   y_q,           y_d;
    logic                frame_valid_q, frame_valid_d;
    logic                sync_err_q,    sync_err_d;
    logic                parity_err_q,  parity_err_d;
    logic                locked_q,      locked_d;

    // Framing FSM, shadow capture and output update.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        shadow_d      = shadow_q;
        y_d           = y_q;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;
        parity_err_d  = 1'b0;

        if (bus.din_valid) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.frame_sync) begin
                        shadow_d[0] = bus.din;
                        cnt_d       = CNT_W'(1);
                        state_d     = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.frame_sync) begin
                        // Sync anywhere but channel 0 abandons the partial frame.
                        sync_err_d  = (cnt_q != '0);
                        shadow_d[0] = bus.din;
                        cnt_d       = CNT_W'(1);
                    end else if (cnt_q == '0) begin
                        sync_err_d = 1'b1;
                        state_d    = ST_IDLE;
                    end else if (cnt_q == CNT_W'(FINAL)) begin
`ifdef TDM_DEMUX_PARITY_EN
                        if (even_parity(shadow_q) == bus.din) begin
                            y_d           = shadow_q;
                            frame_valid_d = 1'b1;
                        end else begin
                            parity_err_d  = 1'b1;
                        end
`else
                        y_d           = {bus.din, shadow_q[NUM_CH-2:0]};
                        frame_valid_d = 1'b1;
`endif
                        cnt_d = '0;
                    end else begin
                        shadow_d[cnt_q[SEL_W-1:0]] = bus.din;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

`ifdef TDM_DEMUX_PARITY_EN
        // Reported index saturates on the parity beat.
        ch_idx_d = (cnt_d == CNT_W'(NUM_CH)) ? SEL_W'(NUM_CH - 1) : cnt_d[SEL_W-1:0];
`else
        ch_idx_d = cnt_d;
`endif
        locked_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            ch_idx_q      <= '0;
            shadow_q      <= '0;
            y_q           <= '0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
            parity_err_q  <= 1'b0;
            locked_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ch_idx_q      <= ch_idx_d;
            shadow_q      <= shadow_d;
            y_q           <= y_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
            parity_err_q  <= parity_err_d;
            locked_q      <= locked_d;
        end
    end

    assign bus.y           = y_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.ch_idx      = ch_idx_q;
    assign bus.locked      = locked_q;
    assign bus.sync_err    = sync_err_q;
    assign bus.parity_err  = parity_err_q;

endmodule

// File: tb/tb_tdm_demux_1to8.sv
// Bench for tdm_demux_1to8: directed frame scenarios plus random beats, every cycle
// compared against a queue-based frame model.
module tb_tdm_demux_1to8;
    import tdm_demux_pkg::*;

`ifdef TDM_DEMUX_PARITY_EN
    localparam int unsigned FRAME_LEN = NUM_CH + 1;
`else
    localparam int unsigned FRAME_LEN = NUM_CH;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    tdm_demux_1to8_if bus();

    tdm_demux_1to8 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: bits collected since the last accepted sync.
    bit                m_locked;
    bit                m_q[$];
    logic [NUM_CH-1:0] m_y;
    bit                m_fv, m_se, m_pe;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_beat(input bit d, input bit v, input bit s, input bit r);
        logic [NUM_CH-1:0] w;
        m_fv = 0; m_se = 0; m_pe = 0;
        if (!r) begin
            m_locked = 0; m_q.delete(); m_y = '0;
        end else if (v) begin
            if (s) begin
                if (m_locked && m_q.size() != 0) m_se = 1;
                m_q.delete(); m_q.push_back(d); m_locked = 1;
            end else if (m_locked) begin
                if (m_q.size() == 0) begin
                    m_se = 1; m_locked = 0;
                end else begin
                    m_q.push_back(d);
                    if (m_q.size() == FRAME_LEN) begin
                        for (int k = 0; k < NUM_CH; k++) w[k] = m_q[k];
                        if (FRAME_LEN == NUM_CH || m_q[FRAME_LEN-1] == ^w) begin
                            m_y = w; m_fv = 1;
                        end else begin
                            m_pe = 1;
                        end
                        m_q.delete();
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        int exp_idx;
        exp_idx = (m_q.size() > NUM_CH - 1) ? NUM_CH - 1 : m_q.size();
        chk("y",           32'(bus.y),           32'(m_y));
        chk("frame_valid", 32'(bus.frame_valid), 32'(m_fv));
        chk("sync_err",    32'(bus.sync_err),    32'(m_se));
        chk("parity_err",  32'(bus.parity_err),  32'(m_pe));
        chk("locked",      32'(bus.locked),      32'(m_locked));
        chk("ch_idx",      32'(bus.ch_idx),      32'(exp_idx));
    endtask

    // One clock: drive, sample at the edge, compare 1 time unit later.
    task automatic step(input bit d, input bit v, input bit s, input bit r);
        bus.din = d; bus.din_valid = v; bus.frame_sync = s; rst_n = r;
        @(posedge clk);
        model_beat(d, v, s, r);
        #1 check_all();
    endtask

    // Serializer: LSB (channel 0) first, optional idle gaps, optional parity corruption.
    task automatic send_frame(input logic [NUM_CH-1:0] w, input bit sync,
                              input int max_gap, input bit bad_par);
        for (int k = 0; k < NUM_CH; k++) begin
            repeat ($urandom_range(0, max_gap)) step(bit'($urandom), 1'b0, 1'b0, 1'b1);
            step(w[k], 1'b1, sync && (k == 0), 1'b1);
        end
`ifdef TDM_DEMUX_PARITY_EN
        step((^w) ^ bad_par, 1'b1, 1'b0, 1'b1);
`else
        if (bad_par) step(1'b0, 1'b0, 1'b0, 1'b1);
`endif
    endtask

    int fv_count;

    initial begin
        bus.din = 0; bus.din_valid = 0; bus.frame_sync = 0; rst_n = 0;
        m_locked = 0; m_y = '0; m_fv = 0; m_se = 0; m_pe = 0;

        // Reset state
        step(0, 0, 0, 0);
        step(1, 1, 1, 0);
        chk("rst_y", 32'(bus.y), 32'h0);
        chk("rst_locked", 32'(bus.locked), 32'h0);

        // Single frame A6
        send_frame(8'hA6, 1, 0, 0);
        chk("a6_y", 32'(bus.y), 32'hA6);
        chk("a6_locked", 32'(bus.locked), 32'h1);

        // Back-to-back A6, 5B
        send_frame(8'hA6, 1, 0, 0);
        send_frame(8'h5B, 1, 0, 0);
        chk("b2b_y", 32'(bus.y), 32'h5B);

        // 3C with din_valid dropped for 3 cycles mid-frame
        for (int k = 0; k < NUM_CH; k++) begin
            if (k == 4) repeat (3) step(1, 0, 1, 1);
            step(k < 6 ? ((8'h3C >> k) & 1) : 0, 1, k == 0, 1);
        end
`ifdef TDM_DEMUX_PARITY_EN
        step(^8'h3C, 1, 0, 1);
`endif
        chk("gap_y", 32'(bus.y), 32'h3C);

        // Sync on beat 4: partial frame dropped, FF restarts from that beat
        for (int k = 0; k < 4; k++) step(bit'(k & 1), 1, k == 0, 1);
        send_frame(8'hFF, 1, 0, 0);
        chk("resync_y", 32'(bus.y), 32'hFF);

        // Missing sync at channel 0 -> unlock, then unsynced beats ignored
        step(1, 1, 0, 1);
        chk("nosync_locked", 32'(bus.locked), 32'h0);
        send_frame(8'h81, 0, 0, 0);
        chk("nosync_y", 32'(bus.y), 32'hFF);

        // Reset at beat 5 of a frame
        for (int k = 0; k < 5; k++) step(1, 1, k == 0, 1);
        step(1, 1, 0, 0);
        fv_count = 0;
        for (int k = 6; k < NUM_CH; k++) begin
            step(1, 1, 0, 1);
            fv_count += int'(bus.frame_valid);
        end
        chk("rstmid_y", 32'(bus.y), 32'h0);
        chk("rstmid_fv", 32'(fv_count), 32'h0);

`ifdef TDM_DEMUX_PARITY_EN
        send_frame(8'hA6, 1, 0, 0);
        chk("par_ok_y", 32'(bus.y), 32'hA6);
        send_frame(8'h5B, 1, 0, 1);
        chk("par_bad_pe", 32'(bus.parity_err), 32'h1);
        chk("par_bad_y", 32'(bus.y), 32'hA6);
`endif

        // Random framed traffic with gaps and occasional parity corruption
        for (int f = 0; f < 40; f++)
            send_frame(NUM_CH'($urandom), ($urandom_range(0, 9) != 0), 2,
                       ($urandom_range(0, 5) == 0));

        // Fully random beats, including syncs, drops and rare resets
        for (int c = 0; c < 400; c++)
            step(bit'($urandom), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 99) != 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
